// File: rtl/uart_receiver.sv
// uart_receiver: UART receiver (start, 8 data bits LSB-first, stop) with a 2-FF synchroniser and FWFT receive buffer.
// Define UART_RECEIVER_PARITY_EN to add an even-parity bit after bit 7 and the parity_error_o output.
module uart_receiver #(
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int BUFFER_DEPTH = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          uart_rx_i,
  input  logic [1:0]                    baudrate_select_i,
  input  logic                          data_read_i,
  input  logic [$clog2(BUFFER_DEPTH):0] data_buffer_ready_tresh_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          data_buffer_empty_o,
  output logic                          data_buffer_ready_o,
  output logic                          frame_error_o,
  output logic                          overrun_o
`ifdef UART_RECEIVER_PARITY_EN
  ,
  output logic                          parity_error_o
`endif
);

  localparam int CNT_W   = $clog2(CLOCK_FREQ / 9600 + 1);
  localparam int PTR_W   = $clog2(BUFFER_DEPTH);
  localparam int FILL_W  = PTR_W + 1;
  localparam int BIT_W   = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0]  CYC_9600   = CNT_W'(CLOCK_FREQ / 9600);
  localparam logic [CNT_W-1:0]  CYC_19200  = CNT_W'(CLOCK_FREQ / 19200);
  localparam logic [CNT_W-1:0]  CYC_57600  = CNT_W'(CLOCK_FREQ / 57600);
  localparam logic [CNT_W-1:0]  CYC_115200 = CNT_W'(CLOCK_FREQ / 115200);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [FILL_W-1:0] FILL_ZERO  = FILL_W'(0);
  localparam logic [FILL_W-1:0] FILL_ONE   = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(BUFFER_DEPTH);
  localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RECEIVER_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

  function automatic logic [CNT_W-1:0] bit_cycles(input logic [1:0] sel);
    logic [CNT_W-1:0] cyc;
    case (sel)
      2'b00:   cyc = CYC_9600;
      2'b01:   cyc = CYC_19200;
      2'b10:   cyc = CYC_57600;
      2'b11:   cyc = CYC_115200;
      default: cyc = CYC_115200;
    endcase
    return cyc;
  endfunction

  logic [2:0]            rx_sync_q;
  logic                  rx_s;
  logic                  rx_prev_s;
  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      bit_cycles_q;
  logic [BIT_W-1:0]      bit_idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  frame_err_q;
  logic                  half_hit_s;
  logic                  bit_hit_s;
  logic                  parity_ok_s;
  logic                  push_s;

  // Stage 0 is metastability capture, stage 1 is rx_s, stage 2 is its previous value for edge detect
  always_ff @(posedge clock_i) begin
    if (reset_i) rx_sync_q <= 3'b111;
    else         rx_sync_q <= {rx_sync_q[1:0], uart_rx_i};
  end

  assign rx_s       = rx_sync_q[1];
  assign rx_prev_s  = rx_sync_q[2];
  assign half_hit_s = (cnt_q == ((bit_cycles_q >> 1) - CNT_ONE));
  assign bit_hit_s  = (cnt_q == (bit_cycles_q - CNT_ONE));

`ifdef UART_RECEIVER_PARITY_EN
  logic parity_q;
  logic parity_err_q;
  assign parity_ok_s    = ~((^shift_q) ^ parity_q);
  assign parity_error_o = parity_err_q;
`else
  assign parity_ok_s = 1'b1;
`endif

  // A good byte leaves the FSM on the stop-sample cycle itself
  assign push_s = (state_q == ST_STOP) && bit_hit_s && rx_s && parity_ok_s;

  // Receive FSM: start detect, mid-bit sampling, stop check and error pulses
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_cycles_q <= CYC_115200;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (rx_prev_s && !rx_s) begin
            state_q      <= ST_START;
            bit_cycles_q <= bit_cycles(baudrate_select_i);
          end
        end
        ST_START: begin
          if (half_hit_s) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (bit_hit_s) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_s;
            bit_idx_q          <= bit_idx_q + BIT_ONE;
            if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RECEIVER_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef UART_RECEIVER_PARITY_EN
        ST_PARITY: begin
          if (bit_hit_s) begin
            cnt_q    <= '0;
            parity_q <= rx_s;
            state_q  <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (bit_hit_s) begin
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            frame_err_q <= ~rx_s;
`ifdef UART_RECEIVER_PARITY_EN
            parity_err_q <= ~parity_ok_s;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  empty_q, ready_q, overrun_q;
  logic                  pop_s, accept_s, ready_d, overrun_d;

  // Buffer next state; data_d tracks the head so data_o stays a plain register
  always_comb begin
    pop_s     = data_read_i && (count_q != FILL_ZERO);
    accept_s  = push_s && ((count_q != FILL_FULL) || pop_s);
    overrun_d = push_s && !accept_s;
    wr_ptr_d  = accept_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    if (accept_s && !pop_s) begin
      count_d = count_q + FILL_ONE;
    end else if (pop_s && !accept_s) begin
      count_d = count_q - FILL_ONE;
    end else begin
      count_d = count_q;
    end
    if (accept_s && ((count_q == FILL_ZERO) || (pop_s && (count_q == FILL_ONE)))) begin
      data_d = shift_q;
    end else if (pop_s && (count_q > FILL_ONE)) begin
      data_d = mem_q[rd_ptr_d];
    end else begin
      data_d = data_q;
    end
    ready_d = (data_buffer_ready_tresh_i != FILL_ZERO) && (count_d >= data_buffer_ready_tresh_i);
  end

  // Buffer storage; contents are only read while valid, so no reset is needed
  always_ff @(posedge clock_i) begin
    if (accept_s) mem_q[wr_ptr_q] <= shift_q;
  end

  // Buffer pointers, fill count and registered status outputs
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_q    <= '0;
      empty_q   <= 1'b1;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      empty_q   <= (count_d == FILL_ZERO);
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o              = data_q;
  assign data_buffer_empty_o = empty_q;
  assign data_buffer_ready_o = ready_q;
  assign frame_error_o       = frame_err_q;
  assign overrun_o           = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed + randomized bench for uart_receiver (CLOCK_FREQ=1_152_000, BUFFER_DEPTH=4).
// Reference model: a byte queue plus expected error-pulse counts, updated per frame sent.
module tb_uart_receiver;

  localparam int CF    = 1_152_000;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       rd    = 1'b0;
  logic [1:0] sel   = 2'b11;
  logic [2:0] tresh = 3'd3;
  logic [7:0] data;
  logic       empty, ready, ferr, ovr;
`ifdef UART_RECEIVER_PARITY_EN
  logic       perr;
`endif

  uart_receiver #(.CLOCK_FREQ(CF), .BUFFER_DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
    .clock_i                  (clock),
    .reset_i                  (reset),
    .uart_rx_i                (rx),
    .baudrate_select_i        (sel),
    .data_read_i              (rd),
    .data_buffer_ready_tresh_i(tresh),
    .data_o                   (data),
    .data_buffer_empty_o      (empty),
    .data_buffer_ready_o      (ready),
    .frame_error_o            (ferr),
    .overrun_o                (ovr)
`ifdef UART_RECEIVER_PARITY_EN
    ,
    .parity_error_o           (perr)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic [7:0] model_q[$];

  // Pulse counters sampled on the falling edge
  always @(negedge clock) begin
    if (ferr === 1'b1) fe_cnt++;
    if (ovr === 1'b1) ov_cnt++;
`ifdef UART_RECEIVER_PARITY_EN
    if (perr === 1'b1) pe_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic int baud_cycles(input logic [1:0] s);
    int rate;
    case (s)
      2'b00:   rate = 9600;
      2'b01:   rate = 19200;
      2'b10:   rate = 57600;
      default: rate = 115200;
    endcase
    return CF / rate;
  endfunction

  task automatic check_state(input string tag);
    logic exp_ready;
    exp_ready = (tresh != 3'd0) && (model_q.size() >= int'(tresh));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".ready"}, 32'(ready), 32'(exp_ready));
    if (model_q.size() > 0) check({tag, ".data"}, 32'(data), 32'(model_q[0]));
    check({tag, ".ferr_cnt"}, fe_cnt, exp_fe);
    check({tag, ".ovr_cnt"}, ov_cnt, exp_ov);
    check({tag, ".perr_cnt"}, pe_cnt, exp_pe);
  endtask

  // Sends one frame at baud s; par_bad flips the parity bit (parity builds only)
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_bad,
                            input logic [1:0] s, input bit scramble, input bit probe);
    logic [11:0] bits;
    int nbits, bc;
    bit parity_wrong;
    bits = 12'hFFF;
    bits[0] = 1'b0;
    bits[8:1] = d;
    nbits = 9;
    parity_wrong = 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
    bits[9] = (^d) ^ par_bad;
    nbits = 10;
    parity_wrong = par_bad;
`endif
    bits[nbits] = stop_v;
    nbits = nbits + 1;
    sel = s;
    bc = baud_cycles(s);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < bc; c++) begin
        rx = bits[b];
        if (scramble && b == 2 && c == 0) sel = 2'($urandom);
        if (probe && b == nbits - 1 && c == 0) check("no_early_push", 32'(empty), 32'd1);
        cyc(1);
      end
    end
    rx = 1'b1;
    cyc(4);
    if (!stop_v) exp_fe++;
    if (parity_wrong) exp_pe++;
    if (stop_v && !parity_wrong) begin
      if (model_q.size() < DEPTH) model_q.push_back(d);
      else exp_ov++;
    end
  endtask

  task automatic read_one(input string tag);
    if (model_q.size() > 0) check({tag, ".head"}, 32'(data), 32'(model_q[0]));
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    cyc(1);
  endtask

  initial begin
    cyc(3);
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.data", 32'(data), 32'd0);
    check("reset.ready", 32'(ready), 32'd0);
    check("reset.ferr", 32'(ferr), 32'd0);
    check("reset.ovr", 32'(ovr), 32'd0);
    reset = 1'b0;
    cyc(2);

    send_frame(8'hA5, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
    check_state("a5");
    read_one("a5_read");
    check_state("a5_after_read");

    rx = 1'b0;
    cyc(3);
    rx = 1'b1;
    cyc(30);
    check_state("glitch");

    send_frame(8'h3C, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    check_state("stop_low");

    tresh = 3'd3;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
      check_state($sformatf("fill%0d", i));
    end
    tresh = 3'd0; cyc(2); check_state("tresh0");
    tresh = 3'd5; cyc(2); check_state("tresh5");
    tresh = 3'd4; cyc(2); check_state("tresh4");
    tresh = 3'd3; cyc(2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), 32'(data), 32'(i + 1));
      read_one("drain");
    end
    check_state("drained");
    read_one("read_empty");
    check_state("read_empty");

    rx = 1'b0;
    cyc(150);
    rx = 1'b1;
    cyc(10);
    exp_fe++;
    check_state("break");
    send_frame(8'h5A, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    check_state("after_break");

    tresh = 3'd1;
    cyc(2);
    check("pre_reset.ready", 32'(ready), 32'd1);
    rx = 1'b0; cyc(10); rx = 1'b1; cyc(10); rx = 1'b0; cyc(15);
    reset = 1'b1;
    rx = 1'b1;
    cyc(2);
    check("midreset.empty", 32'(empty), 32'd1);
    check("midreset.data", 32'(data), 32'd0);
    check("midreset.ready", 32'(ready), 32'd0);
    model_q.delete();
    reset = 1'b0;
    cyc(3);
    send_frame(8'hC3, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    check_state("after_reset");
    read_one("after_reset_read");

`ifdef UART_RECEIVER_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    check_state("parity_bad");
    send_frame(8'h07, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    check_state("parity_good");
    read_one("parity_read");
`endif

    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 4));
      if (op <= 1) begin
        send_frame(8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                   2'($urandom), 1'b1, 1'b0);
      end else if (op <= 3) begin
        read_one("rnd_read");
      end else begin
        tresh = 3'($urandom);
        cyc(2);
      end
      check_state($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
